// File: rtl/assist_lvl_ctrl_if.sv
// Pin-level bundle between the assist-level controller and its surroundings:
// raw button/brake inputs in, level/scale/pulses out.
interface assist_lvl_ctrl_if;
  logic       tgglMd;
  logic       brake_n;
  logic [1:0] setting;
  logic [2:0] scale;
  logic       mode_chg;
  logic       long_prs;

  modport master (
    output tgglMd, brake_n,
    input  setting, scale, mode_chg, long_prs
  );

  modport slave (
    input  tgglMd, brake_n,
    output setting, scale, mode_chg, long_prs
  );
endinterface

// File: rtl/assist_lvl_ctrl.sv
// eBike assist-level front end: debounces the mode button, classifies short/long
// presses, steps the assist level and drives a slew-limited torque scale.
module assist_lvl_ctrl #(
  parameter int unsigned DB_CNT   = 65536,
  parameter int unsigned LONG_CNT = 25000000,
  parameter int unsigned RAMP_CNT = 1000000
) (
  input logic               clk,
  input logic               rst_n,
  assist_lvl_ctrl_if.slave  bus
);

  localparam int unsigned DB_W   = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CNT + 1);
  localparam int unsigned PRE_W  = (RAMP_CNT > 1) ? $clog2(RAMP_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  logic              btn_s1_q, btn_s2_q;
  logic              brk_s1_q, brk_s2_q;
  logic              db_btn_q, db_btn_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic [1:0]        setting_q, setting_d;
  logic [1:0]        last_on_q, last_on_d;
  logic              mode_chg_q, mode_chg_d;
  logic [2:0]        scale_q, scale_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        target_c;
  logic              tick_c;

  // Two-flop synchronisers; brake syncs idle high so reset does not look like braking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      brk_s1_q <= 1'b1;
      brk_s2_q <= 1'b1;
    end else begin
      btn_s1_q <= bus.tgglMd;
      btn_s2_q <= btn_s1_q;
      brk_s1_q <= bus.brake_n;
      brk_s2_q <= brk_s1_q;
    end
  end

  // Debounce: flip only after DB_CNT consecutive disagreeing cycles
  always_comb begin
    db_btn_d = db_btn_q;
    db_cnt_d = '0;
    if (btn_s2_q != db_btn_q) begin
      if (db_cnt_q == DB_W'(DB_CNT - 1)) db_btn_d = btn_s2_q;
      else                               db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Press classifier next-state
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_btn_q) begin
          state_d = PRESS;
          hold_d  = '0;
        end
      end
      PRESS: begin
        if (hold_q == HOLD_W'(LONG_CNT)) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else if (!db_btn_q) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LONG: begin
        if (!db_btn_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Level update, one cycle after the classifying transition
  always_comb begin
    setting_d = setting_q;
    last_on_d = last_on_q;
    if (short_q) begin
      if (setting_q == 2'd0)      setting_d = last_on_q;
      else if (setting_q == 2'd3) setting_d = 2'd1;
      else                        setting_d = setting_q + 2'd1;
    end else if (long_q) begin
      if (setting_q != 2'd0) begin
        last_on_d = setting_q;
        setting_d = 2'd0;
      end else begin
        setting_d = last_on_q;
      end
    end
    mode_chg_d = (setting_d != setting_q);
  end

  always_comb begin
    case (setting_q)
      2'd1:    target_c = 3'd3;
      2'd2:    target_c = 3'd5;
      2'd3:    target_c = 3'd7;
      default: target_c = 3'd0;
    endcase
  end

  // Free-running prescaler; target follows the registered level so a same-cycle change ramps to the old one
  always_comb begin
    tick_c  = (pre_q == PRE_W'(RAMP_CNT - 1));
    pre_d   = tick_c ? '0 : pre_q + PRE_W'(1);
    scale_d = scale_q;
    if (!brk_s2_q)                       scale_d = 3'd0;
    else if (scale_q > target_c)         scale_d = target_c;
    else if (scale_q < target_c && tick_c) scale_d = scale_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_btn_q   <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      hold_q     <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      setting_q  <= 2'd2;
      last_on_q  <= 2'd2;
      mode_chg_q <= 1'b0;
      scale_q    <= 3'd0;
      pre_q      <= '0;
    end else begin
      db_btn_q   <= db_btn_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      short_q    <= short_d;
      long_q     <= long_d;
      setting_q  <= setting_d;
      last_on_q  <= last_on_d;
      mode_chg_q <= mode_chg_d;
      scale_q    <= scale_d;
      pre_q      <= pre_d;
    end
  end

  assign bus.setting  = setting_q;
  assign bus.scale    = scale_q;
  assign bus.mode_chg = mode_chg_q;
  assign bus.long_prs = long_q;

endmodule

// File: tb/tb_assist_lvl_ctrl.sv
// Self-checking bench for assist_lvl_ctrl with short debounce/hold/ramp constants;
// level changes are scoreboarded against a small behavioural model.
module tb_assist_lvl_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  int   exp_set_q[$];
  int   exp_long = 0;
  int   m_set  = 2;
  int   m_last = 2;

  assist_lvl_ctrl_if bus ();

  assist_lvl_ctrl #(
    .DB_CNT  (4),
    .LONG_CNT(50),
    .RAMP_CNT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every mode_chg / long_prs pulse must match a queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.mode_chg === 1'b1) begin
        total++;
        if (exp_set_q.size() == 0) begin
          bad++;
          $display("FAIL mode_chg_unexpected: setting=%0d, required no pulse", bus.setting);
        end else begin
          int e;
          e = exp_set_q.pop_front();
          if (bus.setting !== 2'(e)) begin
            bad++;
            $display("FAIL setting_on_mode_chg: got %0d, required %0d", bus.setting, e);
          end
        end
      end
      if (bus.long_prs === 1'b1) begin
        total++;
        if (exp_long == 0) begin
          bad++;
          $display("FAIL long_prs_unexpected: got pulse, required none");
        end else begin
          exp_long--;
        end
      end
    end
  end

  task automatic push_short();
    if (m_set == 0)      m_set = m_last;
    else if (m_set == 3) m_set = 1;
    else                 m_set = m_set + 1;
    exp_set_q.push_back(m_set);
  endtask

  task automatic push_long();
    if (m_set != 0) begin
      m_last = m_set;
      m_set  = 0;
    end else begin
      m_set = m_last;
    end
    exp_set_q.push_back(m_set);
    exp_long++;
  endtask

  task automatic press_pin(input int hold);
    bus.tgglMd = 1'b1;
    repeat (hold) @(negedge clk);
    bus.tgglMd = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_set_q.size() != 0 || exp_long != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_drain: pending settings=%0d long=%0d, required 0", name, exp_set_q.size(), exp_long);
    end
  endtask

  task automatic wait_mode_chg(input string name);
    int n = 0;
    while (bus.mode_chg !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_timeout: mode_chg never seen, required a pulse", name);
    end
  endtask

  task automatic check_scale(input string name, input int exp);
    total++;
    if (bus.scale !== 3'(exp)) begin
      bad++;
      $display("FAIL %s: scale=%0d, required %0d", name, bus.scale, exp);
    end
  endtask

  task automatic check_setting(input string name, input int exp);
    total++;
    if (bus.setting !== 2'(exp)) begin
      bad++;
      $display("FAIL %s: setting=%0d, required %0d", name, bus.setting, exp);
    end
  endtask

  // Called at the negedge where rst_n has just been released
  task automatic check_reset_ramp(input string name);
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      check_scale(name, (n / 8 > 5) ? 5 : n / 8);
    end
    check_setting({name, "_setting"}, 2);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.tgglMd  = 1'b0;
    bus.brake_n = 1'b1;
    repeat (3) @(negedge clk);
    check_setting("reset_setting", 2);
    check_scale("reset_scale", 0);
    total++;
    if (bus.mode_chg !== 1'b0 || bus.long_prs !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses: mode_chg=%b long_prs=%b, required 0 0", bus.mode_chg, bus.long_prs);
    end
    rst_n = 1'b1;
    m_set = 2;
    m_last = 2;
  endtask

  task automatic test_glitch();
    bus.tgglMd = 1'b1;
    repeat (2) @(negedge clk);
    bus.tgglMd = 1'b0;
    repeat (20) @(negedge clk);
    check_setting("glitch_setting", 2);
    check_scale("glitch_scale", 5);
  endtask

  task automatic test_short_press();
    push_short();
    press_pin(20);
    wait_drain("short1");
    repeat (30) @(negedge clk);
    check_setting("short1_setting", 3);
    check_scale("short1_ramp", 7);

    push_short();
    press_pin(20);
    wait_mode_chg("short2");
    check_scale("short2_old_scale", 7);
    @(negedge clk);
    check_scale("short2_drop", 3);
    wait_drain("short2");
  endtask

  task automatic test_long_press();
    int lp_cyc = -1;
    int mc_cyc = -1;
    int sc59   = -1;
    int sc60   = -1;
    push_short();
    press_pin(20);
    wait_drain("pre_long_a");
    push_short();
    press_pin(20);
    wait_drain("pre_long_b");
    repeat (30) @(negedge clk);
    check_scale("pre_long_scale", 7);

    push_long();
    bus.tgglMd = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.long_prs === 1'b1 && lp_cyc < 0) lp_cyc = n;
      if (bus.mode_chg === 1'b1 && mc_cyc < 0) mc_cyc = n;
      if (n == 59) sc59 = int'(bus.scale);
      if (n == 60) sc60 = int'(bus.scale);
    end
    bus.tgglMd = 1'b0;
    total++;
    if (lp_cyc != 58) begin
      bad++;
      $display("FAIL long_prs_cycle: got %0d, required 58", lp_cyc);
    end
    total++;
    if (mc_cyc != 59) begin
      bad++;
      $display("FAIL long_mode_chg_cycle: got %0d, required 59", mc_cyc);
    end
    total++;
    if (sc59 != 7 || sc60 != 0) begin
      bad++;
      $display("FAIL long_scale_cut: got %0d then %0d, required 7 then 0", sc59, sc60);
    end
    repeat (20) @(negedge clk);
    wait_drain("long");
    check_setting("long_setting", 0);

    push_short();
    press_pin(20);
    wait_drain("long_restore");
    repeat (70) @(negedge clk);
    check_setting("restore_setting", 3);
    check_scale("restore_scale", 7);
  endtask

  task automatic test_brake();
    int prev    = 0;
    int reached = -1;
    int jumps   = 0;
    bus.brake_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_scale("brake_cycle2", 7);
    @(negedge clk);
    check_scale("brake_cycle3", 0);
    repeat (30) @(negedge clk);
    check_scale("brake_hold", 0);
    check_setting("brake_setting", 3);

    bus.brake_n = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (int'(bus.scale) > prev + 1 || int'(bus.scale) < prev) jumps++;
      prev = int'(bus.scale);
      if (bus.scale === 3'd7 && reached < 0) reached = n;
    end
    total++;
    if (jumps != 0) begin
      bad++;
      $display("FAIL brake_release_steps: bad steps=%0d, required 0", jumps);
    end
    total++;
    if (reached < 51 || reached > 58) begin
      bad++;
      $display("FAIL brake_release_ramp: reached 7 at cycle %0d, required 51..58", reached);
    end
  endtask

  task automatic test_brake_press();
    bus.brake_n = 1'b0;
    repeat (5) @(negedge clk);
    push_short();
    press_pin(20);
    wait_drain("brake_press");
    check_setting("brake_press_setting", 1);
    check_scale("brake_press_scale", 0);
    bus.brake_n = 1'b1;
    repeat (40) @(negedge clk);
    check_scale("brake_press_release", 3);
  endtask

  task automatic test_reset_mid_press();
    bus.tgglMd = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_setting("midrst_setting", 2);
    check_scale("midrst_scale", 0);
    bus.tgglMd = 1'b0;
    @(negedge clk);
    exp_set_q.delete();
    exp_long = 0;
    m_set  = 2;
    m_last = 2;
    rst_n  = 1'b1;
    check_reset_ramp("midrst_ramp");
  endtask

  initial begin
    test_reset();
    check_reset_ramp("reset_ramp");
    test_glitch();
    test_short_press();
    test_long_press();
    test_brake();
    test_brake_press();
    test_reset_mid_press();
    wait_drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
